// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-thread register write-tracking scoreboard.
// The issue stage counts each in-flight destination register up and
// writeback counts it down. Decode asks whether its sources (or a full
// destination counter) collide with outstanding writes and gets a stall
// indication. Because writes to the same register are counted, a register
// is released only when its last pending write retires.
//
// Handshake: there is no valid/ready pairing here. issue_valid, wb_valid
// and flush_valid are single-cycle event strobes. Each one is acted on at
// the rising edge where it is sampled high. Nothing is ever back-pressured.
// Respecting stall is the issuer's responsibility, and violations show up
// on the sticky err flag.
module wb_scoreboard #(
  parameter int NTHREADS = 4,
  parameter int TIDW     = 2,
  parameter int NREGS    = 32,
  parameter int REGW     = 5,
  parameter int CNTW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_has_dst,
  input  logic [TIDW-1:0]     issue_thread,
  input  logic [REGW-1:0]     issue_dst,
  input  logic                wb_valid,
  input  logic [TIDW-1:0]     wb_thread,
  input  logic [REGW-1:0]     wb_dst,
  input  logic                flush_valid,
  input  logic [TIDW-1:0]     flush_thread,
  input  logic [TIDW-1:0]     q_thread,
  input  logic [REGW-1:0]     q_src1,
  input  logic [REGW-1:0]     q_src2,
  input  logic                q_has_src2,
  input  logic [REGW-1:0]     q_dst,
  input  logic                q_has_dst,
  output logic                stall,
  output logic [NTHREADS-1:0] pending,
  output logic                err
);

  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [CNTW-1:0] CNT_ZERO = '0;
  localparam logic [CNTW-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

  logic [CNTW-1:0]     cnt_q [NTHREADS][NREGS];
  logic [CNTW-1:0]     cnt_d [NTHREADS][NREGS];
  logic [NTHREADS-1:0] pending_q, pending_d;
  logic                err_q, err_d;

  // Qualified events after flush priority has been applied.
  logic issue_ev, wb_ev, same_slot;

  // Decode hazard check: reads current state only, with no bypass from a
  // writeback in the same cycle.
  always_comb begin
    stall = 1'b0;
    if (cnt_q[q_thread][q_src1] != CNT_ZERO)
      stall = 1'b1;
    if (q_has_src2 && (cnt_q[q_thread][q_src2] != CNT_ZERO))
      stall = 1'b1;
    if (q_has_dst && (cnt_q[q_thread][q_dst] == CNT_MAX))
      stall = 1'b1;
  end

  // Event qualification. A flush of a thread swallows that thread's
  // issue/wb events in the same cycle, and they do not count as errors.
  always_comb begin
    issue_ev  = issue_valid && issue_has_dst &&
                !(flush_valid && (flush_thread == issue_thread));
    wb_ev     = wb_valid &&
                !(flush_valid && (flush_thread == wb_thread));
    same_slot = issue_ev && wb_ev &&
                (issue_thread == wb_thread) && (issue_dst == wb_dst);
  end

  // Next-state counters, error flag and per-thread pending summary.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;

    // An issue and a retire on the same slot cancel out, leaving the count as is.
    if (!same_slot) begin
      if (issue_ev) begin
        if (cnt_q[issue_thread][issue_dst] == CNT_MAX)
          err_d = 1'b1;
        else
          cnt_d[issue_thread][issue_dst] = cnt_q[issue_thread][issue_dst] + CNT_ONE;
      end
      if (wb_ev) begin
        if (cnt_q[wb_thread][wb_dst] == CNT_ZERO)
          err_d = 1'b1;
        else
          cnt_d[wb_thread][wb_dst] = cnt_q[wb_thread][wb_dst] - CNT_ONE;
      end
    end

    if (flush_valid) begin
      for (int r = 0; r < NREGS; r++)
        cnt_d[flush_thread][r] = CNT_ZERO;
    end

    pending_d = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (cnt_d[t][r] != CNT_ZERO)
          pending_d[t] = 1'b1;
      end
    end
  end

  // State registers. Synchronous reset overrides every event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++) begin
        for (int r = 0; r < NREGS; r++)
          cnt_q[t][r] <= CNT_ZERO;
      end
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        for (int r = 0; r < NREGS; r++)
          cnt_q[t][r] <= cnt_d[t][r];
      end
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

endmodule
